iic_slave_resp: RTL and testbench

- I2C target (responder) for the same two-wire bus our master blocks drive.
- Detects START, repeated START and STOP, and matches the 7-bit address.
- Write transfers: ACKs the address and data bytes, presenting each received byte to the fabric.
- Read transfers: serves bytes supplied by the fabric.
- Used as a loopback/emulation target for the SHT21 master path and for bus verification. It runs entirely in the system clock domain, oversampling scl/sda.

---
 rtl/iic_slave_resp_if.sv | 23 ++
 rtl/iic_slave_resp.sv | 220 ++++++++++++++++++++++
 tb/tb_iic_slave_resp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/iic_slave_resp_if.sv
// Fabric-side handshake between the I2C responder and the logic that feeds and consumes its bytes.
interface iic_slave_resp_if;
    logic       rx_ack_en;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_req;
    logic       rw;
    logic       addressed;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  rx_ack_en, tx_data,
        output rx_data, rx_valid, rx_first, tx_req, rw, addressed, start_det, stop_det
    );

    modport master (
        output rx_ack_en, tx_data,
        input  rx_data, rx_valid, rx_first, tx_req, rw, addressed, start_det, stop_det
    );
endinterface

// File: rtl/iic_slave_resp.sv
// I2C target: oversamples scl/sda in the system clock domain, matches a 7-bit address,
// receives write bytes and serves read bytes from the fabric over an open-drain sda.
module iic_slave_resp #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scl,
    inout  wire             sda,
    iic_slave_resp_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_d_q, sda_d_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

    logic [2:0] state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_low_q, sda_low_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_q, rw_d;
    logic       addressed_q, addressed_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       first_q, first_d;
    logic       ack_q, ack_d;

    // Open drain: only ever pull low or release.
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d_q;
    assign scl_fall = ~scl_s & scl_d_q;
    assign start_c  = scl_s & ~sda_s & sda_d_q;
    assign stop_c   = scl_s & sda_s & ~sda_d_q;

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_first  = rx_first_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.rw        = rw_q;
    assign bus.addressed = addressed_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        sda_low_d   = sda_low_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        tx_req_d    = 1'b0;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        first_d     = first_q;
        ack_d       = ack_q;

        if (start_c) begin
            start_det_d = 1'b1;
            sda_low_d   = 1'b0;
            bitcnt_d    = 4'd0;
            addressed_d = 1'b0;
            state_d     = S_ADDR;
        end else if (stop_c) begin
            stop_det_d  = 1'b1;
            sda_low_d   = 1'b0;
            addressed_d = 1'b0;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shreg_d  = {shreg_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (shreg_q[6:0] == SLAVE_ADDR) rw_d = sda_s;
                            else                            state_d = S_WAIT_STOP;
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        sda_low_d = 1'b1;
                        state_d   = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_rise) begin
                        addressed_d = 1'b1;
                        tx_req_d    = rw_q;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            shreg_d   = bus.tx_data;
                            sda_low_d = ~bus.tx_data[7];
                            bitcnt_d  = 4'd1;
                            state_d   = S_RD_DATA;
                        end else begin
                            sda_low_d = 1'b0;
                            bitcnt_d  = 4'd0;
                            first_d   = 1'b1;
                            state_d   = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shreg_d  = {shreg_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        sda_low_d  = bus.rx_ack_en;
                        ack_d      = bus.rx_ack_en;
                        bitcnt_d   = 4'd0;
                        state_d    = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        if (ack_q) begin
                            state_d = S_WR_DATA;
                        end else begin
                            addressed_d = 1'b0;
                            state_d     = S_WAIT_STOP;
                        end
                    end
                end
                S_RD_DATA: begin
                    // bitcnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            state_d   = S_RD_ACK;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_low_d = ~shreg_q[6];
                            bitcnt_d  = bitcnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                        end else begin
                            addressed_d = 1'b0;
                            state_d     = S_WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        shreg_d   = bus.tx_data;
                        sda_low_d = ~bus.tx_data[7];
                        bitcnt_d  = 4'd1;
                        state_d   = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_d_q     <= 1'b1;
            sda_d_q     <= 1'b1;
            state_q     <= S_IDLE;
            bitcnt_q    <= 4'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_low_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            first_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_d_q     <= scl_s;
            sda_d_q     <= sda_s;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            sda_low_q   <= sda_low_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            tx_req_q    <= tx_req_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            first_q     <= first_d;
            ack_q       <= ack_d;
        end
    end
endmodule

// File: tb/tb_iic_slave_resp.sv
// Directed bench: a bit-banged I2C master drives the responder through write, read,
// address-mismatch, repeated-START and mid-transfer reset scenarios.
module tb_iic_slave_resp;
    localparam time T = 100ns;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    iic_slave_resp_if bus_if ();

    iic_slave_resp #(.SLAVE_ADDR(7'h40), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl_m),
        .sda (sda),
        .bus (bus_if.slave)
    );

    always #5ns clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0, n_stop = 0, n_txreq = 0, n_low = 0;
    logic [8:0] rxq[$];

    always @(posedge clk) begin
        if (bus_if.start_det) n_start <= n_start + 1;
        if (bus_if.stop_det)  n_stop  <= n_stop + 1;
        if (bus_if.tx_req)    n_txreq <= n_txreq + 1;
        if (!m_low && sda === 1'b0) n_low <= n_low + 1;
        if (bus_if.rx_valid) rxq.push_back({bus_if.rx_first, bus_if.rx_data});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_low = ~b; #T;
        scl_m = 1'b1; #T;
        s = sda; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(v[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            v[i] = s;
        end
        send_bit(~master_ack, s);
    endtask

    task automatic bus_start();
        m_low = 1'b1; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic bus_rstart();
        m_low = 1'b0; #T;
        scl_m = 1'b1; #T;
        m_low = 1'b1; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #T;
        scl_m = 1'b1; #T;
        m_low = 1'b0; #T;
    endtask

    typedef struct {
        logic [7:0] addr, d0, d1;
        logic       ack_en, e_aack, e_d0ack, e_d1ack;
        int         e_cnt;
        logic [7:0] e_rx0, e_rx1;
    } vec_t;
    vec_t vt[4];

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a0, a1, a2;
        logic [7:0] rb0, rb1;
        int b_start, b_stop, b_tx, b_low, b_rx;

        vt[0] = '{8'h80, 8'hE3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'hE3, 8'h5A};
        vt[1] = '{8'h82, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00};
        vt[2] = '{8'h80, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h11, 8'h00};
        vt[3] = '{8'h80, 8'hAA, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'hAA, 8'h01};

        bus_if.rx_ack_en = 1'b1;
        bus_if.tx_data   = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda", sda, 1'b1);
        check("rst_rx_data", bus_if.rx_data, 8'h00);
        check("rst_flags", {bus_if.rw, bus_if.addressed, bus_if.rx_valid, bus_if.tx_req,
                            bus_if.start_det, bus_if.stop_det, bus_if.rx_first}, 7'd0);
        rst = 1'b0;
        #T;

        for (int i = 0; i < 4; i++) begin
            b_start = n_start; b_stop = n_stop; b_low = n_low; b_rx = rxq.size();
            bus_if.rx_ack_en = vt[i].ack_en;
            bus_start();
            write_byte(vt[i].addr, a0);
            check($sformatf("v%0d_addr_ack", i), a0, vt[i].e_aack);
            check($sformatf("v%0d_addressed", i), bus_if.addressed, vt[i].e_aack);
            write_byte(vt[i].d0, a1);
            write_byte(vt[i].d1, a2);
            check($sformatf("v%0d_d0_ack", i), a1, vt[i].e_d0ack);
            check($sformatf("v%0d_d1_ack", i), a2, vt[i].e_d1ack);
            bus_stop();
            #T;
            check($sformatf("v%0d_rx_cnt", i), rxq.size() - b_rx, vt[i].e_cnt);
            if (vt[i].e_cnt >= 1)
                check($sformatf("v%0d_rx0", i), (rxq.size() > b_rx) ? rxq[b_rx] : 9'h1FF, {1'b1, vt[i].e_rx0});
            if (vt[i].e_cnt >= 2)
                check($sformatf("v%0d_rx1", i), (rxq.size() > b_rx + 1) ? rxq[b_rx + 1] : 9'h1FF, {1'b0, vt[i].e_rx1});
            check($sformatf("v%0d_drove_low", i), n_low != b_low, vt[i].e_aack);
            check($sformatf("v%0d_start_cnt", i), n_start - b_start, 1);
            check($sformatf("v%0d_stop_cnt", i), n_stop - b_stop, 1);
            check($sformatf("v%0d_end_addressed", i), bus_if.addressed, 1'b0);
            check($sformatf("v%0d_rw", i), bus_if.rw, 1'b0);
        end
        bus_if.rx_ack_en = 1'b1;

        // Read two bytes: master ACKs the first, NACKs the second
        b_tx = n_txreq;
        bus_if.tx_data = 8'h66;
        bus_start();
        write_byte(8'h81, a0);
        check("rd_addr_ack", a0, 1'b1);
        check("rd_rw", bus_if.rw, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            logic s;
            send_bit(1'b1, s);
            rb0[i] = s;
        end
        bus_if.tx_data = 8'h7C;
        send_bit(1'b0, a1);
        read_byte(1'b0, rb1);
        check("rd_byte0", rb0, 8'h66);
        check("rd_byte1", rb1, 8'h7C);
        check("rd_tx_req_cnt", n_txreq - b_tx, 2);
        check("rd_nack_addressed", bus_if.addressed, 1'b0);
        check("rd_nack_sda_released", sda, 1'b1);
        bus_stop();
        #T;

        // Repeated START: write one byte, then switch to a read
        b_start = n_start; b_stop = n_stop;
        bus_if.tx_data = 8'h3C;
        bus_start();
        write_byte(8'h80, a0);
        check("sr_rw0", bus_if.rw, 1'b0);
        write_byte(8'hF3, a1);
        check("sr_wr_ack", {a0, a1}, 2'b11);
        bus_rstart();
        write_byte(8'h81, a2);
        check("sr_rd_addr_ack", a2, 1'b1);
        check("sr_rw1", bus_if.rw, 1'b1);
        read_byte(1'b0, rb0);
        check("sr_rd_byte", rb0, 8'h3C);
        bus_stop();
        #T;
        check("sr_start_cnt", n_start - b_start, 2);
        check("sr_stop_cnt", n_stop - b_stop, 1);
        check("sr_rx_data", bus_if.rx_data, 8'hF3);

        // Reset while the responder holds the address ACK low
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            logic s;
            logic [7:0] av;
            av = 8'h80;
            send_bit(av[i], s);
        end
        m_low = 1'b0; #T;
        scl_m = 1'b1; #T;
        check("mr_ack_low", sda, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mr_sda_released", sda, 1'b1);
        check("mr_outputs", {bus_if.rx_data, bus_if.rw, bus_if.addressed}, 10'd0);
        rst = 1'b0;
        #T;
        scl_m = 1'b0; #T;
        bus_stop();
        #T;
        b_rx = rxq.size();
        bus_start();
        write_byte(8'h80, a0);
        write_byte(8'hAA, a1);
        bus_stop();
        #T;
        check("mr_post_acks", {a0, a1}, 2'b11);
        check("mr_post_rx", (rxq.size() == b_rx + 1) ? rxq[b_rx] : 9'h1FF, {1'b1, 8'hAA});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
